sa_mat_fetch: RTL and testbench

Operand fetch engine for the systolic array, downstream of the CSR block that holds the matrix base addresses. On a start pulse it latches the A and B base addresses, reads N×N words of matrix A and then N×N words of matrix B over an AXI-lite read master (one outstanding transaction), and streams each word to the array feeder over a valid/ready interface tagged with matrix select and last flags. It reports busy, a one-cycle done pulse and a sticky read-error flag.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_fetch_addr_gen.sv | 72 +++++++
 rtl/sa_mat_fetch.sv | 160 ++++++++++++++++
 tb/tb_sa_mat_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array operand fetch engine.
package sa_pkg;

    localparam int unsigned N_DEFAULT = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_OUT,
        ST_DONE
    } state_e;

    // Element counter width for an n x n matrix, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/sa_fetch_addr_gen.sv
// Element counter, matrix select and read-address generation for sa_mat_fetch.
// next_addr_c_o is the address of the element selected after this cycle's load/step.
module sa_fetch_addr_gen
    import sa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N          = N_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    output logic                  sel_o,
    output logic                  last_c_o,
    output logic [ADDR_WIDTH-1:0] next_addr_c_o
);

    localparam int unsigned NN     = N * N;
    localparam int unsigned IDX_W  = idx_width(N);
    localparam int unsigned STRIDE = DATA_WIDTH / 8;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NN - 1);

    logic [ADDR_WIDTH-1:0] base_a_q, base_a_d;
    logic [ADDR_WIDTH-1:0] base_b_q, base_b_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  sel_q, sel_d;

    always_comb begin
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        if (load_i) begin
            base_a_d = addr_a_i;
            base_b_d = addr_b_i;
            idx_d    = '0;
            sel_d    = 1'b0;
        end else if (step_i) begin
            // End of A rolls over into the first element of B.
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
                sel_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Address arithmetic wraps modulo 2^ADDR_WIDTH by truncation.
    assign next_addr_c_o = (sel_d ? base_b_d : base_a_d)
                         + ADDR_WIDTH'(idx_d) * ADDR_WIDTH'(STRIDE);
    assign last_c_o      = (idx_q == IDX_MAX);
    assign sel_o         = sel_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_a_q <= '0;
            base_b_q <= '0;
            idx_q    <= '0;
            sel_q    <= 1'b0;
        end else begin
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
        end
    end

endmodule

// File: rtl/sa_mat_fetch.sv
// Operand fetch engine: reads N*N words of A then B over AXI-lite and streams them out.
// Build option: SA_FETCH_ERR_ABORT_EN ends the fetch on the first non-OKAY read response.
module sa_mat_fetch
    import sa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N          = N_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr_A,
    input  logic [ADDR_WIDTH-1:0] i_addr_B,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sel,
    output logic                  o_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  sel_q;
    logic                  last_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic                  load_c;
    logic                  step_c;
    logic                  gen_sel;
    logic                  gen_last_c;
    logic [ADDR_WIDTH-1:0] gen_addr_c;

    assign load_c = (state_q == ST_IDLE) && i_start;
    assign step_c = (state_q == ST_OUT) && i_ready && !(last_q && sel_q);

    sa_fetch_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N)
    ) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (load_c),
        .step_i        (step_c),
        .addr_a_i      (i_addr_A),
        .addr_b_i      (i_addr_B),
        .sel_o         (gen_sel),
        .last_c_o      (gen_last_c),
        .next_addr_c_o (gen_addr_c)
    );

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            data_q    <= '0;
            sel_q     <= 1'b0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        araddr_q  <= gen_addr_c;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (m_axil_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_axil_rvalid) begin
                        rready_q <= 1'b0;
                        if (m_axil_rresp != RESP_OKAY) begin
                            err_q <= 1'b1;
                        end
`ifdef SA_FETCH_ERR_ABORT_EN
                        if (m_axil_rresp != RESP_OKAY) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else
`endif
                        begin
                            data_q  <= m_axil_rdata;
                            sel_q   <= gen_sel;
                            last_q  <= gen_last_c;
                            valid_q <= 1'b1;
                            state_q <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        if (last_q && sel_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            araddr_q  <= gen_addr_c;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign o_data         = data_q;
    assign o_sel          = sel_q;
    assign o_last         = last_q;
    assign o_valid        = valid_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_sa_mat_fetch.sv
// Scoreboard bench for sa_mat_fetch (N=2): AXI-lite slave returning address as data, stalling sink.
module tb_sa_mat_fetch;
    import sa_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NM = 2;
    localparam int          NN = 4;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [AW-1:0] i_addr_A;
    logic [AW-1:0] i_addr_B;
    logic [AW-1:0] m_axil_araddr;
    logic [2:0]    m_axil_arprot;
    logic          m_axil_arvalid;
    logic          m_axil_arready;
    logic [DW-1:0] m_axil_rdata;
    logic [1:0]    m_axil_rresp;
    logic          m_axil_rvalid;
    logic          m_axil_rready;
    logic [DW-1:0] o_data;
    logic          o_sel;
    logic          o_last;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    sa_mat_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N(NM)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_addr_A       (i_addr_A),
        .i_addr_B       (i_addr_B),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready),
        .o_data         (o_data),
        .o_sel          (o_sel),
        .o_last         (o_last),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [AW-1:0] exp_ar[$];
    logic [33:0]   exp_beat[$];

    int ar_delay  = 0;
    int rdy_delay = 0;
    int err_read  = -1;
    int rd_cnt    = 0;

    // AXI-lite slave: arready after ar_delay wait cycles, rvalid the cycle after AR.
    logic          ar_fire, r_fire, ar_hold;
    logic [AW-1:0] lat_addr, ar_addr_h;
    int            ar_wait;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_axil_arready = 1'b0;
            m_axil_rvalid  = 1'b0;
            m_axil_rdata   = '0;
            m_axil_rresp   = 2'b00;
            ar_fire = 1'b0; r_fire = 1'b0; ar_hold = 1'b0; ar_wait = 0;
        end else begin
            if (r_fire) m_axil_rvalid = 1'b0;
            if (ar_fire) begin
                m_axil_rvalid = 1'b1;
                m_axil_rdata  = lat_addr;
                m_axil_rresp  = (rd_cnt == err_read) ? RESP_SLVERR : RESP_OKAY;
                rd_cnt++;
            end
            ar_fire = 1'b0;
            if (m_axil_arvalid) begin
                if (!ar_hold) begin
                    ar_hold   = 1'b1;
                    ar_addr_h = m_axil_araddr;
                end else begin
                    chk("araddr_stable", 64'(m_axil_araddr), 64'(ar_addr_h));
                end
                if (ar_wait >= ar_delay) begin
                    m_axil_arready = 1'b1;
                    ar_fire  = 1'b1;
                    lat_addr = m_axil_araddr;
                    ar_hold  = 1'b0;
                    ar_wait  = 0;
                    if (exp_ar.size() == 0) chk("ar_extra", 64'(exp_ar.size()), 64'd1);
                    else chk("araddr", 64'(m_axil_araddr), 64'(exp_ar.pop_front()));
                end else begin
                    m_axil_arready = 1'b0;
                    ar_wait++;
                end
            end else begin
                m_axil_arready = 1'b0;
            end
            r_fire = m_axil_rvalid && m_axil_rready;
        end
    end

    // Stream sink: holds i_ready low rdy_delay cycles per beat and checks held values.
    logic        snk_hold;
    logic [33:0] snk_val;
    int          snk_stall;
    always @(negedge clk) begin
        if (!rst_n) begin
            i_ready   = 1'b0;
            snk_hold  = 1'b0;
            snk_stall = 0;
        end else if (o_valid) begin
            if (!snk_hold) begin
                snk_hold  = 1'b1;
                snk_val   = {o_sel, o_last, o_data};
                snk_stall = 0;
            end else begin
                chk("beat_stable", 64'({o_sel, o_last, o_data}), 64'(snk_val));
            end
            if (snk_stall >= rdy_delay) begin
                i_ready  = 1'b1;
                snk_hold = 1'b0;
                if (exp_beat.size() == 0) chk("beat_extra", 64'(exp_beat.size()), 64'd1);
                else chk("beat", 64'({o_sel, o_last, o_data}), 64'(exp_beat.pop_front()));
            end else begin
                i_ready = 1'b0;
                snk_stall++;
            end
        end else begin
            i_ready = 1'b0;
        end
    end

    // Expected address and beat sequences from the bases and the injected error.
    task automatic fill(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int errr);
        int n_reads;
        logic [AW-1:0] a;
        n_reads = 2 * NN;
`ifdef SA_FETCH_ERR_ABORT_EN
        if (errr >= 0) n_reads = errr + 1;
`endif
        for (int i = 0; i < n_reads; i++) begin
            a = ((i >= NN) ? bb : ba) + AW'((i % NN) * 4);
            exp_ar.push_back(a);
`ifdef SA_FETCH_ERR_ABORT_EN
            if (i != errr)
`endif
                exp_beat.push_back({(i >= NN), ((i % NN) == NN - 1), a});
        end
    endtask

    task automatic run(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int ard,
                       input int rdd, input int errr, input int midc, input int exp_cyc);
        int  cyc;
        logic done;
        ar_delay = ard; rdy_delay = rdd; err_read = errr; rd_cnt = 0;
        fill(ba, bb, errr);
        @(negedge clk);
        i_addr_A = ba; i_addr_B = bb; i_start = 1'b1;
        cyc = 1; done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                chk("start_busy_arvalid", 64'({o_busy, m_axil_arvalid}), 64'd3);
                chk("start_err_clr", 64'(o_err), 64'd0);
            end
            i_start = (cyc == midc);
            if (cyc == midc) begin
                i_addr_A = ba ^ 32'h00F0_0000;
                i_addr_B = bb ^ 32'h0F00_0000;
            end
            if (o_done) done = 1'b1;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
        else begin
            if (exp_cyc > 0) chk("done_cycle", 64'(cyc), 64'(exp_cyc));
            chk("err_flag", 64'(o_err), 64'(errr >= 0));
            chk("done_busy", 64'(o_busy), 64'd1);
        end
        if (midc > 0) i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("after_done", 64'({o_done, o_busy, m_axil_arvalid}), 64'd0);
        chk("ar_left", 64'(exp_ar.size()), 64'd0);
        chk("beats_left", 64'(exp_beat.size()), 64'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, 64'({m_axil_araddr, o_data}), 64'd0);
        chk(tag, 64'({m_axil_arprot, m_axil_arvalid, m_axil_rready, o_sel, o_last,
                      o_valid, o_busy, o_done, o_err}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_addr_A = '0; i_addr_B = '0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset_outs");
        rst_n = 1'b1;

        run(32'h0000_1000, 32'h0000_2000, 0, 0, -1, 0, 6 * NN + 2);
        run(32'h0000_1000, 32'h0000_2000, 3, 5, -1, 0, 0);
        run(32'h0000_1000, 32'h0000_2000, 0, 0, 2, 0, 0);
        run(32'h0000_3000, 32'h0000_4000, 0, 2, -1, 10, 0);

        // Reset while a beat is stalled in the output stage.
        ar_delay = 0; rdy_delay = 1000; err_read = -1; rd_cnt = 0;
        fill(32'h0000_7000, 32'h0000_8000, -1);
        @(negedge clk);
        i_addr_A = 32'h0000_7000; i_addr_B = 32'h0000_8000; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int k = 0; k < 50 && !o_valid; k++) @(negedge clk);
        chk("mid_valid", 64'(o_valid), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("mid_reset_outs");
        @(negedge clk);
        exp_ar.delete(); exp_beat.delete();
        rst_n = 1'b1;
        run(32'h0000_5000, 32'h0000_6000, 0, 0, -1, 0, 6 * NN + 2);

        run(32'hFFFF_FFF8, 32'h0000_0100, 1, 1, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
